// File: rtl/chol_recon_2_pkg.sv
// Shared definitions for the 2x2 Cholesky reconstruction block (A = L * L^T).
// Holds the element geometry, the indices of the packed lower-triangular elements,
// the one-hot FSM encoding, the saturation constants and the Q16.16 extract/saturate
// helper used on every result element.
package chol_recon_2_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FRAC_W = 16;
  localparam int unsigned PROD_W = 2 * DATA_W;

  // Element positions inside the 3*DATA_W packed vectors.
  localparam int unsigned IDX11 = 0;
  localparam int unsigned IDX21 = 1;
  localparam int unsigned IDX22 = 2;

  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [4:0] {
    StIdle   = 5'b00001,
    StIssue1 = 5'b00010,
    StIssue2 = 5'b00100,
    StWait   = 5'b01000,
    StSum    = 5'b10000
  } state_e;

  // Takes a signed Q32.32 value held at PROD_W+1 bits and returns bits [47:16]
  // (truncation toward -inf). If the discarded upper bits are not a sign extension
  // of bit 47 the result is clamped to the most positive/negative Q16.16 value.
  function automatic logic [DATA_W-1:0] q_extract_sat(input logic [PROD_W:0] v);
    logic [PROD_W:DATA_W+FRAC_W-1] top;
    top = v[PROD_W:DATA_W+FRAC_W-1];
    if ((&top) || !(|top)) begin
      return v[DATA_W+FRAC_W-1:FRAC_W];
    end else if (v[PROD_W]) begin
      return SAT_NEG;
    end else begin
      return SAT_POS;
    end
  endfunction

endpackage

// File: rtl/chol_recon_2_if.sv
// Request/result bundle for chol_recon_2.
//   L       : packed factor {L22, L21, L11}, signed Q16.16
//   L_valid : start request
//   A       : packed result {A22, A21, A11}, signed Q16.16
//   A_valid : result valid (level, held until next accepted start)
//   busy    : operation in flight
// master = requester side, slave = chol_recon_2 side.
interface chol_recon_2_if;

  logic [3*chol_recon_2_pkg::DATA_W-1:0] L;
  logic                                  L_valid;
  logic [3*chol_recon_2_pkg::DATA_W-1:0] A;
  logic                                  A_valid;
  logic                                  busy;

  modport master (
    output L,
    output L_valid,
    input  A,
    input  A_valid,
    input  busy
  );

  modport slave (
    input  L,
    input  L_valid,
    output A,
    output A_valid,
    output busy
  );

endinterface

// File: rtl/chol_recon_2_mult.sv
// q16_mult_pipe: signed DATA_W x DATA_W multiplier followed by Latency register
// stages, all advancing only when en_i is high. Full PROD_W-bit product.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset, clears every stage
//   en_i   : pipeline advance enable
//   a_i/b_i: signed operands
//   p_o    : product, valid Latency enabled cycles after the operands
module q16_mult_pipe
  import chol_recon_2_pkg::*;
#(
  parameter int unsigned Latency = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [PROD_W-1:0] p_o
);

  logic signed [PROD_W-1:0] stage_q [Latency];
  logic signed [PROD_W-1:0] stage_d [Latency];
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;

  always_comb begin
    a_ext      = PROD_W'(a_i);
    b_ext      = PROD_W'(b_i);
    stage_d[0] = a_ext * b_ext;
    for (int i = 1; i < int'(Latency); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Latency); i++) begin
        stage_q[i] <= '0;
      end
    end else if (en_i) begin
      stage_q <= stage_d;
    end
  end

  assign p_o = stage_q[Latency-1];

endmodule

// File: rtl/chol_recon_2.sv
// chol_recon_2: rebuilds the symmetric 2x2 matrix A = L * L^T from its packed
// lower-triangular Cholesky factor, both in signed Q16.16.
//   clk    : system clock
//   rst_n  : synchronous active-low reset (overrides clk_en)
//   clk_en : global stall; when low all state and the multiplier pipelines hold
//   bus    : slave side of chol_recon_2_if (L/L_valid in, A/A_valid/busy out)
// Two multipliers are fed on consecutive cycles (pair 1: L11*L11, L21*L11;
// pair 2: L21*L21, L22*L22); A_valid rises MULT_LATENCY+3 enabled cycles after
// a start is accepted.
module chol_recon_2
  import chol_recon_2_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  chol_recon_2_if.slave   bus
);

  localparam int unsigned CntW = $clog2(MULT_LATENCY) + 1;
  localparam int unsigned VecW = 3 * DATA_W;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [VecW-1:0]     l_q, l_d;
  logic [VecW-1:0]     a_q, a_d;
  logic                a_valid_q, a_valid_d;
  logic                busy_q, busy_d;
  // One bit wider than a product so the sum of two squares cannot wrap.
  logic [PROD_W:0]     sum_q, sum_d;

  logic signed [DATA_W-1:0] l11, l21, l22;
  logic signed [DATA_W-1:0] m0_a, m0_b, m1_a, m1_b;
  logic signed [PROD_W-1:0] p0, p1;

  assign l11 = l_q[IDX11*DATA_W +: DATA_W];
  assign l21 = l_q[IDX21*DATA_W +: DATA_W];
  assign l22 = l_q[IDX22*DATA_W +: DATA_W];

  q16_mult_pipe #(
    .Latency (MULT_LATENCY)
  ) u_mult0 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (clk_en),
    .a_i    (m0_a),
    .b_i    (m0_b),
    .p_o    (p0)
  );

  q16_mult_pipe #(
    .Latency (MULT_LATENCY)
  ) u_mult1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (clk_en),
    .a_i    (m1_a),
    .b_i    (m1_b),
    .p_o    (p1)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    l_d       = l_q;
    a_d       = a_q;
    a_valid_d = a_valid_q;
    busy_d    = busy_q;
    sum_d     = sum_q;
    m0_a      = '0;
    m0_b      = '0;
    m1_a      = '0;
    m1_b      = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.L_valid) begin
          l_d       = bus.L;
          a_valid_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = StIssue1;
        end
      end
      StIssue1: begin
        m0_a    = l11;
        m0_b    = l11;
        m1_a    = l21;
        m1_b    = l11;
        state_d = StIssue2;
      end
      StIssue2: begin
        m0_a    = l21;
        m0_b    = l21;
        m1_a    = l22;
        m1_b    = l22;
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // Pair 1 leaves the pipes one cycle before pair 2.
        if (cnt_q == CntW'(MULT_LATENCY - 2)) begin
          a_d[IDX11*DATA_W +: DATA_W] = q_extract_sat({p0[PROD_W-1], p0});
          a_d[IDX21*DATA_W +: DATA_W] = q_extract_sat({p1[PROD_W-1], p1});
        end
        if (cnt_q == CntW'(MULT_LATENCY - 1)) begin
          sum_d   = {p0[PROD_W-1], p0} + {p1[PROD_W-1], p1};
          state_d = StSum;
        end
      end
      StSum: begin
        a_d[IDX22*DATA_W +: DATA_W] = q_extract_sat(sum_q);
        a_valid_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      l_q       <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      sum_q     <= '0;
    end else if (clk_en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      l_q       <= l_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      busy_q    <= busy_d;
      sum_q     <= sum_d;
    end
  end

  assign bus.A       = a_q;
  assign bus.A_valid = a_valid_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_chol_recon_2.sv
// Self-checking bench for chol_recon_2: a table of factor/result vectors run
// back to back, plus hand-written busy-ignore, stall and mid-operation reset
// sequences. Expected results go through a scoreboard queue.
module tb_chol_recon_2;

  typedef struct {
    logic [31:0] l11;
    logic [31:0] l21;
    logic [31:0] l22;
    logic [31:0] a11;
    logic [31:0] a21;
    logic [31:0] a22;
  } vec_t;

  typedef struct {
    logic [31:0] a11;
    logic [31:0] a21;
    logic [31:0] a22;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b1;

  chol_recon_2_if bus ();

  chol_recon_2 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Start one operation and wait for its result. stall_at/stall_len drop clk_en
  // for stall_len cycles starting at that cycle count; extra_at > 0 fires a
  // bogus L_valid that lands on that edge while the block is busy.
  task automatic do_op(input vec_t v, input int stall_at, input int stall_len,
                       input int extra_at);
    exp_t e;
    exp_t want;
    int   cyc;
    @(negedge clk);
    bus.L       = {v.l22, v.l21, v.l11};
    bus.L_valid = 1'b1;
    e.a11 = v.a11;
    e.a21 = v.a21;
    e.a22 = v.a22;
    sb.push_back(e);
    @(negedge clk);
    bus.L_valid = 1'b0;
    bus.L       = ~bus.L;  // must not leak into the result
    check("accept_valid_low", 32'(bus.A_valid), 32'd0);
    check("accept_busy_high", 32'(bus.busy), 32'd1);
    cyc = 0;
    while (!bus.A_valid && cyc < 60) begin
      if (cyc == stall_at) clk_en = 1'b0;
      if (cyc == stall_at + stall_len) clk_en = 1'b1;
      if (extra_at > 0 && cyc == extra_at - 1) begin
        bus.L       = 96'h0005_0000_0003_0000_0007_0000;
        bus.L_valid = 1'b1;
      end else begin
        bus.L_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    clk_en      = 1'b1;
    bus.L_valid = 1'b0;
    check("latency", 32'(cyc), 32'(10 + stall_len));
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      want = sb.pop_front();
      check("A11", bus.A[31:0], want.a11);
      check("A21", bus.A[63:32], want.a21);
      check("A22", bus.A[95:64], want.a22);
    end
    check("done_busy_low", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic stray;
    bus.L       = '0;
    bus.L_valid = 1'b0;

    vecs[0] = '{32'h0001_0000, 32'h0000_0000, 32'h0001_0000,
                32'h0001_0000, 32'h0000_0000, 32'h0001_0000};  // identity
    vecs[1] = '{32'h0002_0000, 32'h0000_8000, 32'h0001_8000,
                32'h0004_0000, 32'h0001_0000, 32'h0002_8000};  // general
    vecs[2] = '{32'h0003_0000, 32'hFFFF_0000, 32'h0000_0000,
                32'h0009_0000, 32'hFFFD_0000, 32'h0001_0000};  // negative L21
    vecs[3] = '{32'h0100_0000, 32'h0000_0000, 32'h0000_0000,
                32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000};  // positive saturation
    vecs[4] = '{32'h0100_0000, 32'hFF00_0000, 32'h0000_0000,
                32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};  // negative saturation
    vecs[5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000,
                32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};  // truncation to -inf
    vecs[6] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000,
                32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF};  // A22 sum needs 65 bits
    vecs[7] = '{32'h0001_8000, 32'hFFFF_4000, 32'h0000_2000,
                32'h0002_4000, 32'hFFFE_E000, 32'h0000_9400};  // fractional mix

    repeat (3) @(negedge clk);
    check("reset_A", 32'(|bus.A), 32'd0);
    check("reset_valid", 32'(bus.A_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // Back to back: each start after the first lands while A_valid is high.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i], -1, 0, 0);
    end

    // Second request at cycle 4 is ignored.
    do_op(vecs[1], -1, 0, 4);
    repeat (12) @(negedge clk);
    check("ignored_hold_valid", 32'(bus.A_valid), 32'd1);
    check("ignored_hold_A22", bus.A[95:64], 32'h0002_8000);

    // Five stalled cycles in the wait phase.
    do_op(vecs[2], 4, 5, 0);

    // Reset on cycle 5 of an operation.
    @(negedge clk);
    bus.L       = {vecs[7].l22, vecs[7].l21, vecs[7].l11};
    bus.L_valid = 1'b1;
    @(negedge clk);
    bus.L_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_A", 32'(|bus.A), 32'd0);
    check("midrst_valid", 32'(bus.A_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    stray = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.A_valid || bus.busy) stray = 1'b1;
    end
    check("midrst_no_stale", 32'(stray), 32'd0);
    do_op(vecs[1], -1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
